// File: rtl/design_ip_fifo_slave.sv
// Memory-mapped FIFO peripheral on a simple sel/write bus.
// DATA pushes on write and pops on read. STATUS, CTRL and THRESH provide
// sticky error flags, flush and a level-threshold interrupt.
module design_ip_fifo_slave #(
   parameter int BUS_WIDTH  = 32,
   parameter int DATA_WIDTH = 64,
   parameter int FIFO_DEPTH = 512
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BUS_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  write,
   input  logic                  sel,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rvalid,
   output logic                  irq
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_THRESH = 2'd3;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d, thresh_q, thresh_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d;
   logic                  irq_en_q, irq_en_d, irq_q, irq_d;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;

   logic                  mapped;
   logic [1:0]            reg_sel;
   logic                  wr_acc, rd_acc;
   logic                  empty, full;
   logic                  do_push, pop_from_mem;
   logic [DATA_WIDTH-1:0] reg_word;

   // Upper address bits must be zero for an access to hit a register.
   generate
      if (BUS_WIDTH > 2) begin : g_upper_decode
         assign mapped = (addr[BUS_WIDTH-1:2] == '0);
      end else begin : g_no_upper
         assign mapped = 1'b1;
      end
   endgenerate

   assign reg_sel = addr[1:0];
   assign wr_acc  = sel & write & mapped & ~rst;
   // Every read gets rvalid, mapped or not; unmapped reads return 0.
   assign rd_acc  = sel & ~write & ~rst;
   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(FIFO_DEPTH));

   assign do_push      = wr_acc & (reg_sel == REG_DATA) & ~full;
   assign pop_from_mem = rd_acc & mapped & (reg_sel == REG_DATA) & ~empty;

   // Register read mux for non-FIFO sources (DATA pops come from memory).
   always_comb begin
      reg_word = '0;
      if (mapped) begin
         case (reg_sel)
            REG_STATUS: begin
               reg_word[0]      = empty;
               reg_word[1]      = full;
               reg_word[2]      = ovf_q;
               reg_word[3]      = udf_q;
               reg_word[CW+7:8] = count_q;
            end
            REG_CTRL:   reg_word[1]    = irq_en_q;
            REG_THRESH: reg_word[CW-1:0] = thresh_q;
            default:    reg_word = '0;
         endcase
      end
   end

   // Next-state for pointers, level, flags and interrupt.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      thresh_d = thresh_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      irq_en_d = irq_en_q;
      if (wr_acc) begin
         case (reg_sel)
            REG_DATA: begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = count_q + CW'(1);
               end
            end
            REG_STATUS: begin
               if (wdata[2]) ovf_d = 1'b0;
               if (wdata[3]) udf_d = 1'b0;
            end
            REG_CTRL: begin
               irq_en_d = wdata[1];
               if (wdata[0]) begin
                  wr_ptr_d = '0;
                  rd_ptr_d = '0;
                  count_d  = '0;
               end
            end
            default: thresh_d = wdata[CW-1:0];
         endcase
      end
      if (rd_acc && mapped && reg_sel == REG_DATA) begin
         if (empty) begin
            udf_d = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
         end
      end
      irq_d = irq_en_d & (((thresh_d != '0) && (count_d >= thresh_d)) | ovf_d | udf_d);
   end

   // State registers; reset discards queued data but leaves storage alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         thresh_q <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         thresh_q <= thresh_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         rvalid_q <= rd_acc;
      end
   end

   // FIFO storage write port (no reset so it maps onto block RAM).
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wdata;
   end

   // Registered read data; holds its value between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_acc) begin
         rdata_q <= pop_from_mem ? mem[rd_ptr_q] : reg_word;
      end
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign irq    = irq_q;
endmodule

// File: tb/tb_design_ip_fifo_slave.sv
// Scoreboard bench for design_ip_fifo_slave with a 4-deep, 32-bit FIFO.
module tb_design_ip_fifo_slave;
   localparam int BW = 8;
   localparam int DW = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [BW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          write;
   logic          sel;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          irq;

   design_ip_fifo_slave #(
      .BUS_WIDTH(BW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .write(write),
      .sel(sel), .rdata(rdata), .rvalid(rvalid), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic [DW-1:0] data;
   } exp_t;

   exp_t         exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;

   // Reference model of the FIFO contents and flags.
   logic [DW-1:0] m_fifo[$];
   bit            m_ovf = 0;
   bit            m_udf = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_status();
      logic [DW-1:0] s;
      s = '0;
      s[0] = (m_fifo.size() == 0);
      s[1] = (m_fifo.size() == DEPTH);
      s[2] = m_ovf;
      s[3] = m_udf;
      s[10:8] = 3'(m_fifo.size());
      return s;
   endfunction

   task automatic bus_write(input logic [BW-1:0] a, input logic [DW-1:0] d);
      @(negedge clk);
      sel = 1'b1; write = 1'b1; addr = a; wdata = d;
      $display("WR addr=%0h data=%0h", a, d);
   endtask

   task automatic bus_read(input logic [BW-1:0] a, input logic [DW-1:0] e, input string tag);
      exp_t x;
      @(negedge clk);
      sel = 1'b1; write = 1'b0; addr = a; wdata = '0;
      x.tag = tag; x.data = e;
      exp_q.push_back(x);
   endtask

   task automatic idle();
      @(negedge clk);
      sel = 1'b0; write = 1'b0; addr = '0;
   endtask

   task automatic push(input logic [DW-1:0] v);
      bus_write(8'h00, v);
      if (m_fifo.size() < DEPTH) m_fifo.push_back(v);
      else m_ovf = 1;
   endtask

   task automatic pop(input string tag);
      logic [DW-1:0] e;
      if (m_fifo.size() > 0) e = m_fifo.pop_front();
      else begin
         e = '0;
         m_udf = 1;
      end
      bus_read(8'h00, e, tag);
   endtask

   task automatic rd_status(input string tag);
      bus_read(8'h01, m_status(), tag);
   endtask

   // Read-response monitor: rvalid must follow exactly one cycle after a read.
   bit mon_was_read;
   always @(posedge clk) begin
      exp_t e;
      mon_was_read = sel && !write && !rst;
      #1;
      if (rvalid || mon_was_read) begin
         check_val("rvalid", rvalid, mon_was_read);
         if (mon_was_read) begin
            if (exp_q.size() == 0) begin
               check_val("sb_nonempty", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check_val(e.tag, rdata, e.data);
               $display("RD %s rdata=%0h expected=%0h", e.tag, rdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; sel = 1'b0; write = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_val("rst_rdata", rdata, 0);
      check_val("rst_rvalid", rvalid, 0);
      check_val("rst_irq", irq, 0);

      // Reset state and unmapped access
      bus_read(8'h01, 32'h0000_0001, "status_reset");
      bus_read(8'h10, 32'h0, "unmapped_rd");
      bus_write(8'h10, 32'hDEAD_BEEF);
      bus_read(8'h01, 32'h0000_0001, "status_unmapped_wr");

      // Fill, overflow, drain in order
      push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
      bus_read(8'h01, 32'h0000_0402, "status_full");
      push(32'hA5);
      bus_read(8'h01, 32'h0000_0406, "status_ovf");
      for (int i = 0; i < 4; i++) pop("pop_order");

      // Alternate push/pop across pointer wrap
      for (int i = 0; i < 10; i++) begin
         push(32'h100 + 32'(i) * 32'h11);
         pop("wrap_pop");
      end
      pop("pop_empty");
      rd_status("status_udf");
      bus_write(8'h01, 32'h0C);
      m_ovf = 0; m_udf = 0;
      bus_read(8'h01, 32'h0000_0001, "status_w1c");

      // Threshold interrupt
      bus_write(8'h03, 32'h3);
      bus_write(8'h02, 32'h2);
      bus_read(8'h02, 32'h2, "ctrl_rd");
      bus_read(8'h03, 32'h3, "thresh_rd");
      push(32'hB1); push(32'hB2);
      idle(); check_val("irq_below", irq, 0);
      push(32'hB3);
      idle(); check_val("irq_at_thresh", irq, 1);
      pop("thr_pop");
      idle(); check_val("irq_after_pop", irq, 0);
      pop("thr_drain"); pop("thr_drain");

      // Flush
      push(32'hC1); push(32'hC2); push(32'hC3);
      idle(); check_val("irq_pre_flush", irq, 1);
      bus_write(8'h02, 32'h1);
      m_fifo.delete();
      idle(); check_val("irq_flush", irq, 0);
      bus_read(8'h01, 32'h0000_0001, "status_flush");
      bus_read(8'h02, 32'h0, "ctrl_after_flush");
      pop("pop_after_flush");
      rd_status("status_after_flush_pop");

      // Reset mid-stream with a concurrent write
      push(32'hD1); push(32'hD2);
      @(negedge clk);
      rst = 1'b1; sel = 1'b1; write = 1'b1; addr = '0; wdata = 32'hBAD;
      @(negedge clk);
      rst = 1'b0; sel = 1'b0; write = 1'b0;
      m_fifo.delete(); m_ovf = 0; m_udf = 0;
      check_val("midrst_rvalid", rvalid, 0);
      check_val("midrst_irq", irq, 0);
      bus_read(8'h01, 32'h0000_0001, "status_midrst");
      pop("pop_after_rst");

      idle();
      idle();
      idle();
      check_val("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
